pipeline_exec_ctrl: RTL and testbench
=====================================

// Module: pipeline_exec_ctrl
// PURPOSE
//  Run sequencer for the 5-stage MIPS pipeline. Gates pipeline advance (o_valid -> control unit i_valid
//  and stage-register enables) and PC write in continuous or single-step mode. Detects the HALT opcode
//  in IF, freezes the PC, drains in-flight instructions and reports completion plus the executed-cycle count.
// PARAMETERS
//  N_BITS        32          instruction width
//  N_BITS_OP     6           opcode width; opcode = i_instruccion[N_BITS-1 -: N_BITS_OP]
//  HALT_OPCODE   6'b111111   opcode that terminates a program
//  DRAIN_CYCLES  4           advance cycles after HALT fetch (ID, EX, MEM, WB); >= 1
//  N_BITS_CNT    32          cycle counter width
// PORTS
//  i_clk          in   1           clock, rising edge
//  i_reset        in   1           synchronous, active-high
//  i_start        in   1           pulse: begin program; mode taken from i_mode in same cycle
//  i_mode         in   1           0 = continuous, 1 = single-step
//  i_step         in   1           pulse: advance one cycle (step mode only)
//  i_abort        in   1           return to IDLE from any state
//  i_ack          in   1           clears DONE
//  i_instruccion  in   N_BITS      instruction currently in IF
//  o_valid        out  1           pipeline advance enable
//  o_pc_en        out  1           PC write enable
//  o_halt         out  1           to control unit i_halt: squash newly decoded instructions
//  o_busy         out  1           state not IDLE and not DONE
//  o_done         out  1           level, high in DONE
//  o_cycle_count  out  N_BITS_CNT  number of cycles with o_valid=1 since last start
//  o_state        out  3           IDLE=0 RUN=1 STEP_WAIT=2 STEP=3 DRAIN=4 DONE=5
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; o_cycle_count=0; drain counter 0.
//  - All outputs are decoded from registered state/counters (Moore); no combinational input->output path.
//  - IDLE: outputs 0. i_start: clear count; i_mode=0 -> RUN, i_mode=1 -> STEP_WAIT. Start at cycle t -> first o_valid at t+1.
//  - RUN: o_valid=1, o_pc_en=1, o_halt=0. i_step ignored.
//  - STEP_WAIT: o_valid=0, o_pc_en=0. i_step -> STEP.
//  - STEP: exactly one cycle, o_valid=1, o_pc_en=1; next state STEP_WAIT.
//  - HALT detection: only in RUN or STEP, when opcode==HALT_OPCODE. Next state DRAIN, drain counter loaded with DRAIN_CYCLES.
//    The HALT cycle itself still advances (o_valid=1), so HALT enters IF/ID.
//  - DRAIN: o_valid=1, o_pc_en=0, o_halt=1. Runs automatically in both modes; i_step ignored.
//    Counter decrements each cycle; when counter==1 -> DONE. Exactly DRAIN_CYCLES cycles.
//  - DONE: o_done=1, o_valid=0; count held. i_ack -> IDLE. i_start in DONE is ignored.
//  - Counter: +1 in every cycle with o_valid=1 (RUN, STEP, DRAIN); saturates at all-ones, no wrap.
//  - i_abort: any state except IDLE -> IDLE next cycle; count held (not cleared).
//  - Priority in the same cycle: i_reset > i_abort > HALT detect > i_step/i_start.
//  - i_start while busy is ignored. i_step outside STEP_WAIT is ignored.
//  - Reset mid-run: behaves as power-on reset, count cleared.
// TESTING
//  1 Reset, then start(mode=0) at c0; 3 instrs then HALT -> o_valid 1 at c1..c8, o_pc_en 0 from c5,
//    o_halt 1 at c5..c8, o_done=1 at c9, count=8.
//  2 Step mode, same program: 4 i_step pulses -> one o_valid cycle each; after 4th step, DRAIN 4 cycles
//    with no step required; DONE; count=8.
//  3 i_abort in DRAIN (2nd cycle) -> IDLE next cycle, o_valid=0, count=6 held; new start clears to 0.
//  4 i_step and i_abort same cycle in STEP_WAIT -> IDLE, no o_valid pulse.
//    i_start during RUN -> no effect on state or count.
//  5 N_BITS_CNT=3, 10-instruction program -> count saturates at 7.
//    DONE + i_ack -> IDLE; i_start in DONE ignored.
//  6 i_reset asserted in RUN -> next cycle all outputs 0, state IDLE, count 0.

Source files
------------

// File: rtl/pipeline_exec_ctrl.sv
// Run sequencer for the 5-stage pipeline: gates advance and PC write in continuous or
// single-step mode, drains the pipe after a HALT fetch and counts advancing cycles.
module pipeline_exec_ctrl #(
    parameter int unsigned          N_BITS       = 32,
    parameter int unsigned          N_BITS_OP    = 6,
    parameter logic [N_BITS_OP-1:0] HALT_OPCODE  = 6'b111111,
    parameter int unsigned          DRAIN_CYCLES = 4,
    parameter int unsigned          N_BITS_CNT   = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_mode,
    input  logic                  i_step,
    input  logic                  i_abort,
    input  logic                  i_ack,
    input  logic [N_BITS-1:0]     i_instruccion,
    output logic                  o_valid,
    output logic                  o_pc_en,
    output logic                  o_halt,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [N_BITS_CNT-1:0] o_cycle_count,
    output logic [2:0]            o_state
);

    localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StRun      = 3'd1,
        StStepWait = 3'd2,
        StStep     = 3'd3,
        StDrain    = 3'd4,
        StDone     = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic [DW-1:0]         drain_q, drain_d;
    logic [N_BITS_CNT-1:0] count_q, count_d;
    logic                  is_halt;
    logic                  advance;

    assign is_halt = (i_instruccion[N_BITS-1 -: N_BITS_OP] == HALT_OPCODE);
    assign advance = (state_q == StRun) || (state_q == StStep) || (state_q == StDrain);

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        count_d = count_q;
        // The count reflects the current cycle's advance even if the state is left this cycle.
        if (advance && (count_q != '1)) begin
            count_d = count_q + N_BITS_CNT'(1);
        end
        if (i_abort) begin
            state_d = StIdle;
            drain_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        count_d = '0;
                        state_d = i_mode ? StStepWait : StRun;
                    end
                end
                StRun: begin
                    if (is_halt) begin
                        state_d = StDrain;
                        drain_d = DW'(DRAIN_CYCLES);
                    end
                end
                StStepWait: begin
                    if (i_step) begin
                        state_d = StStep;
                    end
                end
                StStep: begin
                    if (is_halt) begin
                        state_d = StDrain;
                        drain_d = DW'(DRAIN_CYCLES);
                    end else begin
                        state_d = StStepWait;
                    end
                end
                StDrain: begin
                    if (drain_q == DW'(1)) begin
                        state_d = StDone;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q - DW'(1);
                    end
                end
                StDone: begin
                    if (i_ack) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
            drain_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            count_q <= count_d;
        end
    end

    assign o_valid       = advance;
    assign o_pc_en       = (state_q == StRun) || (state_q == StStep);
    assign o_halt        = (state_q == StDrain);
    assign o_busy        = (state_q != StIdle) && (state_q != StDone);
    assign o_done        = (state_q == StDone);
    assign o_cycle_count = count_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Directed bench for pipeline_exec_ctrl; a second instance with a 3-bit counter
// shares all inputs and is used for the saturation check.
module tb_pipeline_exec_ctrl;

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] HALT = 32'hFC00_0000;

    // {valid, pc_en, halt, busy, done, state[2:0]}
    localparam logic [7:0] E_IDLE  = 8'b0000_0000;
    localparam logic [7:0] E_RUN   = 8'b1101_0001;
    localparam logic [7:0] E_SWAIT = 8'b0001_0010;
    localparam logic [7:0] E_STEP  = 8'b1101_0011;
    localparam logic [7:0] E_DRAIN = 8'b1011_0100;
    localparam logic [7:0] E_DONE  = 8'b0000_1101;

    logic        clk = 1'b0;
    logic        reset, start, mode, step, abort_in, ack;
    logic [31:0] instr;
    logic        valid, pc_en, halt, busy, done;
    logic [31:0] count;
    logic [2:0]  state;
    logic        s_valid, s_pc_en, s_halt, s_busy, s_done;
    logic [2:0]  s_count;
    logic [2:0]  s_state;
    logic [7:0]  obs;

    int pass_cnt = 0;
    int check_cnt = 0;

    always #5 clk = ~clk;

    assign obs = {valid, pc_en, halt, busy, done, state};

    pipeline_exec_ctrl dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_mode(mode), .i_step(step),
        .i_abort(abort_in), .i_ack(ack), .i_instruccion(instr),
        .o_valid(valid), .o_pc_en(pc_en), .o_halt(halt), .o_busy(busy), .o_done(done),
        .o_cycle_count(count), .o_state(state)
    );

    pipeline_exec_ctrl #(.N_BITS_CNT(3)) dut_small (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_mode(mode), .i_step(step),
        .i_abort(abort_in), .i_ack(ack), .i_instruccion(instr),
        .o_valid(s_valid), .o_pc_en(s_pc_en), .o_halt(s_halt), .o_busy(s_busy),
        .o_done(s_done), .o_cycle_count(s_count), .o_state(s_state)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; mode = 0; step = 0; abort_in = 0; ack = 0; instr = NOP;
        cyc(); cyc();
        reset = 1'b0;
        check_cnt++;
        if (obs !== E_IDLE) $display("FAIL reset_outputs: got %b want %b", obs, E_IDLE);
        else pass_cnt++;
        check_cnt++;
        if (count !== 32'd0) $display("FAIL reset_count: got %0d want 0", count);
        else pass_cnt++;
    endtask

    task automatic test_run();
        start = 1; mode = 0; instr = NOP;
        cyc();
        start = 0;
        for (int k = 1; k <= 8; k++) begin
            instr = (k == 4) ? HALT : NOP;
            check_cnt++;
            if (obs !== ((k <= 4) ? E_RUN : E_DRAIN))
                $display("FAIL run_state c%0d: got %b want %b", k, obs,
                         (k <= 4) ? E_RUN : E_DRAIN);
            else pass_cnt++;
            check_cnt++;
            if (count !== 32'(k - 1)) $display("FAIL run_count c%0d: got %0d want %0d", k, count, k - 1);
            else pass_cnt++;
            cyc();
        end
        instr = NOP;
        check_cnt++;
        if (obs !== E_DONE) $display("FAIL run_done: got %b want %b", obs, E_DONE);
        else pass_cnt++;
        check_cnt++;
        if (count !== 32'd8) $display("FAIL run_final_count: got %0d want 8", count);
        else pass_cnt++;
        ack = 1; cyc(); ack = 0;
        check_cnt++;
        if (obs !== E_IDLE) $display("FAIL run_ack: got %b want %b", obs, E_IDLE);
        else pass_cnt++;
    endtask

    task automatic test_step();
        start = 1; mode = 1; instr = NOP;
        cyc();
        start = 0;
        check_cnt++;
        if (obs !== E_SWAIT || count !== 32'd0)
            $display("FAIL step_enter: got %b/%0d want %b/0", obs, count, E_SWAIT);
        else pass_cnt++;
        for (int s = 1; s <= 4; s++) begin
            cyc(); cyc();
            check_cnt++;
            if (obs !== E_SWAIT) $display("FAIL step_wait s%0d: got %b want %b", s, obs, E_SWAIT);
            else pass_cnt++;
            step = 1; cyc(); step = 0;
            instr = (s == 4) ? HALT : NOP;
            check_cnt++;
            if (obs !== E_STEP) $display("FAIL step_pulse s%0d: got %b want %b", s, obs, E_STEP);
            else pass_cnt++;
            cyc();
            instr = NOP;
        end
        for (int d = 1; d <= 4; d++) begin
            step = (d == 2);
            check_cnt++;
            if (obs !== E_DRAIN) $display("FAIL step_drain d%0d: got %b want %b", d, obs, E_DRAIN);
            else pass_cnt++;
            cyc();
        end
        step = 0;
        check_cnt++;
        if (obs !== E_DONE || count !== 32'd8)
            $display("FAIL step_done: got %b/%0d want %b/8", obs, count, E_DONE);
        else pass_cnt++;
        ack = 1; cyc(); ack = 0;
    endtask

    task automatic test_abort_drain();
        start = 1; mode = 0; instr = NOP;
        cyc();
        start = 0;
        for (int k = 1; k <= 5; k++) begin
            instr = (k == 4) ? HALT : NOP;
            cyc();
        end
        instr = NOP;
        check_cnt++;
        if (obs !== E_DRAIN) $display("FAIL abort_pre: got %b want %b", obs, E_DRAIN);
        else pass_cnt++;
        abort_in = 1; cyc(); abort_in = 0;
        check_cnt++;
        if (obs !== E_IDLE || count !== 32'd6)
            $display("FAIL abort_drain: got %b/%0d want %b/6", obs, count, E_IDLE);
        else pass_cnt++;
        cyc();
        start = 1; cyc(); start = 0;
        check_cnt++;
        if (obs !== E_RUN || count !== 32'd0)
            $display("FAIL abort_restart: got %b/%0d want %b/0", obs, count, E_RUN);
        else pass_cnt++;
        abort_in = 1; cyc(); abort_in = 0;
        check_cnt++;
        if (obs !== E_IDLE || count !== 32'd1)
            $display("FAIL abort_run: got %b/%0d want %b/1", obs, count, E_IDLE);
        else pass_cnt++;
    endtask

    task automatic test_step_abort();
        start = 1; mode = 1; cyc(); start = 0;
        step = 1; abort_in = 1; cyc(); step = 0; abort_in = 0;
        check_cnt++;
        if (obs !== E_IDLE || count !== 32'd0)
            $display("FAIL step_abort: got %b/%0d want %b/0", obs, count, E_IDLE);
        else pass_cnt++;
        start = 1; mode = 0; cyc();
        // start stays high while in RUN and must be ignored
        cyc(); start = 0;
        check_cnt++;
        if (obs !== E_RUN || count !== 32'd1)
            $display("FAIL start_in_run: got %b/%0d want %b/1", obs, count, E_RUN);
        else pass_cnt++;
        abort_in = 1; cyc(); abort_in = 0;
    endtask

    task automatic test_saturate();
        start = 1; mode = 0; cyc(); start = 0;
        for (int k = 1; k <= 10; k++) begin
            instr = (k == 10) ? HALT : NOP;
            cyc();
        end
        instr = NOP;
        cyc(); cyc(); cyc(); cyc();
        check_cnt++;
        if (s_done !== 1'b1 || s_count !== 3'd7)
            $display("FAIL sat_small: got done=%b count=%0d want done=1 count=7", s_done, s_count);
        else pass_cnt++;
        check_cnt++;
        if (obs !== E_DONE || count !== 32'd14)
            $display("FAIL sat_wide: got %b/%0d want %b/14", obs, count, E_DONE);
        else pass_cnt++;
        start = 1; cyc(); start = 0;
        check_cnt++;
        if (obs !== E_DONE || count !== 32'd14)
            $display("FAIL start_in_done: got %b/%0d want %b/14", obs, count, E_DONE);
        else pass_cnt++;
        ack = 1; cyc(); ack = 0;
        check_cnt++;
        if (obs !== E_IDLE || count !== 32'd14)
            $display("FAIL done_ack: got %b/%0d want %b/14", obs, count, E_IDLE);
        else pass_cnt++;
    endtask

    task automatic test_reset_midrun();
        start = 1; mode = 0; cyc(); start = 0;
        cyc(); cyc();
        check_cnt++;
        if (obs !== E_RUN || count !== 32'd2)
            $display("FAIL midrun_pre: got %b/%0d want %b/2", obs, count, E_RUN);
        else pass_cnt++;
        reset = 1; cyc(); reset = 0;
        check_cnt++;
        if (obs !== E_IDLE || count !== 32'd0)
            $display("FAIL midrun_reset: got %b/%0d want %b/0", obs, count, E_IDLE);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_run();
        test_step();
        test_abort_drain();
        test_step_abort();
        test_saturate();
        test_reset_midrun();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
